// File: rtl/apb_cmd_master_if.sv
// Port bundle of the APB-side bridge engine: command FIFO read port,
// response FIFO write port and the APB3 master bus.
interface apb_cmd_master_if #(
  parameter int DATA_WIDTH  = 73,
  parameter int ADDR_WIDTH  = 32,
  parameter int PDATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]  cmd_rdata;
  logic                   cmd_empty;
  logic                   cmd_ren;
  logic [PDATA_WIDTH:0]   resp_wdata;
  logic                   resp_full;
  logic                   resp_wen;
  logic [ADDR_WIDTH-1:0]  paddr;
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [PDATA_WIDTH-1:0] pwdata;
  logic [3:0]             pstrb;
  logic [2:0]             pprot;
  logic                   pready;
  logic [PDATA_WIDTH-1:0] prdata;
  logic                   pslverr;

  modport master (
    input  cmd_rdata, cmd_empty, resp_full, pready, prdata, pslverr,
    output cmd_ren, resp_wdata, resp_wen,
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot
  );

  modport slave (
    output cmd_rdata, cmd_empty, resp_full, pready, prdata, pslverr,
    input  cmd_ren, resp_wdata, resp_wen,
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB-side engine of the AHB-APB bridge: pops one command, runs one APB3
// transfer with a PREADY timeout, and pushes one {pslverr, prdata} response.
module apb_cmd_master #(
  parameter int DATA_WIDTH     = 73,
  parameter int ADDR_WIDTH     = 32,
  parameter int PDATA_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             rclk,
  input  logic             reset,
  apb_cmd_master_if.master bus,
  output logic             busy,
  output logic             timeout
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic                   write;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [PDATA_WIDTH-1:0] wdata;
    logic [3:0]             strb;
    logic [2:0]             prot;
    logic                   rsvd;
  } cmd_t;

  state_t                 state_q, state_d;
  cmd_t                   cmd;
  logic                   fetch;
  logic                   access_done;
  logic                   timed_out;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PDATA_WIDTH:0]   resp_q, resp_d;
  logic                   resp_wen_q, resp_wen_d;
  logic                   timeout_q;
  logic [ADDR_WIDTH-1:0]  paddr_q;
  logic                   pwrite_q;
  logic [PDATA_WIDTH-1:0] pwdata_q;
  logic [3:0]             pstrb_q;
  logic [2:0]             pprot_q;
  logic                   unused_rsvd;

  assign cmd         = cmd_t'(bus.cmd_rdata);
  assign unused_rsvd = cmd.rsvd;
  assign fetch       = (state_q == IDLE) && !bus.cmd_empty;
  assign bus.cmd_ren = fetch && !reset;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: each variable gets a default before the case so no path through
  // this block leaves it unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    access_done = 1'b0;
    timed_out   = 1'b0;
    cnt_d       = cnt_q;
    resp_d      = resp_q;
    resp_wen_d  = 1'b0;
    unique case (state_q)
      IDLE:   if (fetch) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        // A late PREADY on the last allowed cycle still completes normally.
        if (bus.pready) begin
          access_done = 1'b1;
          resp_d      = {bus.pslverr, pwrite_q ? {PDATA_WIDTH{1'b0}} : bus.prdata};
        end else if (cnt_q == CNT_LIMIT) begin
          access_done = 1'b1;
          timed_out   = 1'b1;
          resp_d      = {1'b1, {PDATA_WIDTH{1'b0}}};
        end
        if (access_done) begin
          state_d    = RESP;
          cnt_d      = '0;
          resp_wen_d = !bus.resp_full;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        // Only this engine fills the response FIFO, so a one-cycle-old
        // not-full sample cannot be invalidated before the push lands.
        if (resp_wen_q) state_d = IDLE;
        else            resp_wen_d = !bus.resp_full;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      resp_q     <= '0;
      resp_wen_q <= 1'b0;
      timeout_q  <= 1'b0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      pprot_q    <= '0;
    end else begin
      if (fetch) begin
        paddr_q  <= cmd.addr;
        pwrite_q <= cmd.write;
        pwdata_q <= cmd.wdata;
        pstrb_q  <= cmd.write ? cmd.strb : 4'b0000;
        pprot_q  <= cmd.prot;
      end
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
      resp_wen_q <= resp_wen_d;
      timeout_q  <= timed_out;
    end
  end

  assign bus.psel       = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable    = (state_q == ACCESS);
  assign bus.paddr      = paddr_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.pstrb      = pstrb_q;
  assign bus.pprot      = pprot_q;
  assign bus.resp_wdata = resp_q;
  assign bus.resp_wen   = resp_wen_q;
  assign busy           = (state_q != IDLE);
  assign timeout        = timeout_q;
endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Single-clock APB-side engine of the AHB-APB bridge.
- Pops 73-bit commands from the read port of the command async FIFO and runs one APB3 master transfer per command.
- Pushes a 33-bit response {pslverr, prdata} into the response FIFO, which returns it to the AHB side.
- Includes a PREADY timeout so a hung slave cannot stall the bridge.

Parameters:
DATA_WIDTH, 73, command word width; layout is fixed as below.
ADDR_WIDTH, 32, PADDR width.
PDATA_WIDTH, 32, PWDATA/PRDATA width; response width is PDATA_WIDTH+1.
TIMEOUT_CYCLES, 16, max ACCESS cycles without PREADY before forced error (legal range 1..255).

Ports:
rclk  input  1  clock; same clock as the command FIFO read side.
reset  input  1  asynchronous, active-high reset.
cmd_rdata  input  DATA_WIDTH  command FIFO head word (valid when cmd_empty=0).
cmd_empty  input  1  command FIFO empty.
cmd_ren  output  1  command FIFO pop.
resp_wdata  output  PDATA_WIDTH+1  response word {pslverr, prdata}.
resp_full  input  1  response FIFO full.
resp_wen  output  1  response FIFO push.
paddr  output  ADDR_WIDTH  APB address.
psel  output  1  APB select.
penable  output  1  APB enable.
pwrite  output  1  APB direction.
pwdata  output  PDATA_WIDTH  APB write data.
pstrb  output  4  APB write strobes.
pprot  output  3  APB protection.
pready  input  1  APB ready.
prdata  input  PDATA_WIDTH  APB read data.
pslverr  input  1  APB slave error.
busy  output  1  high in any state other than IDLE.
timeout  output  1  one-cycle pulse when a transfer is aborted by timeout.

Behaviour:
- Command layout:
  - [72] write.
  - [71:40] addr.
  - [39:8] wdata.
  - [7:4] strb.
  - [3:1] prot.
  - [0] reserved, ignored.
- Reset (asynchronous, reset=1), all outputs 0:
  - state=IDLE.
  - psel=0, penable=0, pwrite=0.
  - paddr=0, pwdata=0, pstrb=0, pprot=0.
  - resp_wdata=0, resp_wen=0, busy=0, timeout=0.
  - Timeout counter=0.
- cmd_ren is combinational: cmd_ren = (state==IDLE) & ~cmd_empty & ~reset. It is high for exactly one cycle per command.
- IDLE:
  - If ~cmd_empty: latch the command fields into registers at the edge and go to SETUP.
  - Else stay in IDLE.
- SETUP:
  - psel=1, penable=0; paddr/pwrite/pwdata/pprot driven from the latched command.
  - pstrb = strb when write, 0 when read.
  - Go to ACCESS unconditionally.
- ACCESS:
  - psel=1, penable=1; address, control and data held stable.
  - The counter increments each ACCESS cycle with pready=0.
  - If pready=1: capture resp = {pslverr, write ? 0 : prdata}, drop psel/penable, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: capture resp = {1, 0}, pulse timeout, drop psel/penable, go to RESP.
  - If pready=1 arrives in the same cycle the counter reaches the limit, pready wins: normal completion, no timeout pulse.
- RESP:
  - resp_wdata is held stable.
  - resp_wen = ~resp_full, registered so it is high for one cycle on entry when there is room.
  - After a successful push go to IDLE and clear the counter.
  - While resp_full=1, stay in RESP with resp_wen=0. The next command is not fetched; this gives backpressure to the command FIFO.
- Latency: command present in IDLE at cycle 0 gives:
  - SETUP at cycle 1.
  - ACCESS at cycle 2.
  - With pready=1 at cycle 2: resp_wen at cycle 3, IDLE at cycle 4.
  - Minimum 4 cycles per command. There is no back-to-back SETUP.
- Every command produces exactly one response, including writes and timeouts. Order is preserved.
- Reset mid-transfer: the transfer is abandoned immediately, psel/penable drop asynchronously, and no response is written.
- Counter width is $clog2(TIMEOUT_CYCLES)+1 bits. It never wraps, because it is cleared on leaving ACCESS.

Test Plan:
1. Single read: cmd addr=0x0000_1000, write=0, prot=3'b010. Slave pready=1 in the first ACCESS, prdata=0xDEAD_BEEF, pslverr=0. Required:
   - psel high cycles 1-2, penable cycle 2, paddr=0x1000, pprot=2.
   - resp_wdata=0x0_DEAD_BEEF with resp_wen at cycle 3.
2. Write with wait states: write=1, addr=0x20, wdata=0x1234_5678, strb=4'b0011. pready low 3 cycles. Required:
   - ACCESS lasts 4 cycles, pwdata/pstrb stable throughout.
   - resp_wdata=33'h0_0000_0000.
3. Timeout: read with pready held 0 and TIMEOUT_CYCLES=16. Required:
   - ACCESS lasts exactly 16 cycles, then a one-cycle timeout pulse.
   - resp_wdata=33'h1_0000_0000.
   - The next command is serviced normally.
4. Slave error plus backpressure: read returns pslverr=1, prdata=0xA5A5_A5A5, while resp_full=1 for 5 cycles. Required:
   - Stays in RESP with resp_wen=0 and cmd_ren=0 for 5 cycles.
   - Then resp_wen with 33'h1_A5A5_A5A5.
5. Stream: 3 queued commands (2 reads, 1 write) with zero-wait slave. Required:
   - Exactly 3 cmd_ren pulses spaced 4 cycles apart.
   - 3 responses in order, no extra APB transfers.
6. Reset during ACCESS: assert reset mid-wait. Required:
   - psel/penable/busy go 0 immediately, no resp_wen.
   - After deassertion, the pending FIFO head is fetched fresh.
